// File: rtl/alu_mul_sequencer_pkg.sv
// Shared constants for the ALU-sequenced multiplier: ALU opcodes it issues and its FSM state encoding.
package alu_mul_sequencer_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SHR  = 4'b0101;
    localparam logic [3:0] ALU_SHL  = 4'b0110;
    localparam logic [3:0] ALU_ZERO = 4'b1111;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADD  = 3'd1;
    localparam logic [2:0] S_SHL  = 3'd2;
    localparam logic [2:0] S_SHR  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 16-bit multiplier that borrows the shared ALU, one ALU op per clock.
// Latency: done pulses 1+3n cycles after start (n = MSB index of operand_b + 1, 0 if b==0).
// Backpressure: none; start is only accepted in IDLE, otherwise dropped (not queued).
module alu_mul_sequencer
    import alu_mul_sequencer_pkg::*;
#(
    parameter int         WIDTH       = 16,
    parameter logic [3:0] IDLE_OPCODE = ALU_ZERO
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [3:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_z
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       cnt;

    // ALU drive is a pure function of state so the datapath mux sees stable inputs all cycle.
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        alu_x      = '0;
        alu_y      = '0;
        alu_opcode = IDLE_OPCODE;
        case (state)
            S_ADD: begin
                busy       = 1'b1;
                alu_x      = acc;
                alu_y      = a;
                alu_opcode = ALU_ADD;
            end
            S_SHL: begin
                busy       = 1'b1;
                alu_x      = a;
                alu_y      = ONE;
                alu_opcode = ALU_SHL;
            end
            S_SHR: begin
                busy       = 1'b1;
                alu_x      = b;
                alu_y      = ONE;
                alu_opcode = ALU_SHR;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            acc     <= '0;
            a       <= '0;
            b       <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a   <= operand_a;
                        b   <= operand_b;
                        acc <= '0;
                        cnt <= '0;
                        if (operand_b == '0) begin
                            state   <= S_DONE;
                            product <= '0;
                        end else begin
                            state <= S_ADD;
                        end
                    end
                end
                S_ADD: begin
                    if (b[0])
                        acc <= alu_z;
                    state <= S_SHL;
                end
                S_SHL: begin
                    a     <= alu_z;
                    state <= S_SHR;
                end
                S_SHR: begin
                    b   <= alu_z;
                    cnt <= cnt + 4'd1;
                    // Stop early once the remaining multiplier bits are all zero.
                    if (alu_z == '0 || cnt == 4'd15) begin
                        state   <= S_DONE;
                        product <= acc;
                    end else begin
                        state <= S_ADD;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
